// File: rtl/alu_mc_pkg.sv
// Opcode map, FSM state encoding and shared helpers for the multi-cycle ALU.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_REM   = 4'b1101;
  localparam logic [3:0] OP_BLT   = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative MUL (shift-add) and DIV/REM (restoring, on magnitudes) datapath.
// done is high during the last of WIDTH busy cycles; result/ovf are valid alongside it.
module alu_mc_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_busy;
  logic [SHW-1:0]   r_cnt;
  logic             r_is_mul;
  logic             r_is_rem;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_a;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;

  always_comb begin
    w_a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    w_b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  // MUL: acc accumulates, x is the multiplier (shifts right), y the multiplicand (shifts left).
  // DIV/REM: acc is the partial remainder, x shifts the dividend out and the quotient in.
  always_comb begin
    w_rem_sh  = {r_acc[WIDTH-2:0], r_x[WIDTH-1]};
    w_diff    = {1'b0, w_rem_sh} - {1'b0, r_y};
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (r_is_mul) begin
      w_acc_nxt = r_x[0] ? (r_acc + r_y) : r_acc;
      w_x_nxt   = r_x >> 1;
      w_y_nxt   = r_y << 1;
    end else if (!w_diff[WIDTH]) begin
      w_acc_nxt = w_diff[WIDTH-1:0];
      w_x_nxt   = {r_x[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nxt = w_rem_sh;
      w_x_nxt   = {r_x[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    done   = r_busy && (r_cnt == SHW'(WIDTH - 1));
    ovf    = r_ovf;
    result = '0;
    if (r_is_mul) begin
      result = w_acc_nxt;
    end else if (r_is_rem) begin
      if (r_div0)       result = r_a;
      else if (r_neg_r) result = ~w_acc_nxt + 1'b1;
      else              result = w_acc_nxt;
    end else begin
      if (r_div0)       result = '1;
      else if (r_neg_q) result = ~w_x_nxt + 1'b1;
      else              result = w_x_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_is_rem <= 1'b0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_a      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_is_mul <= (op == OP_MUL);
      r_is_rem <= (op == OP_REM);
      r_acc    <= '0;
      r_x      <= (op == OP_MUL) ? b : w_a_mag;
      r_y      <= (op == OP_MUL) ? a : w_b_mag;
      r_a      <= a;
      r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg_r  <= a[WIDTH-1];
      r_div0   <= (b == '0);
      r_ovf    <= (op == OP_DIV) && (a == MIN_VAL) && (b == '1);
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on request and result sides.
// Define ALU_MULDIV_EN to build iterative MUL/DIV/REM; otherwise those opcodes act as NOP.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             branch_taken
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;
  logic             r_branch;

  logic             w_accept;
  logic             w_mc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [SHW-1:0]   w_sh;
  logic             w_add_v;
  logic             w_sub_v;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_br;
  logic             w_live;

`ifdef ALU_MULDIV_EN
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_result;
  logic             w_md_ovf;

  assign w_mc = is_multicycle(opcode);

  alu_mc_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_accept && w_mc),
    .op     (opcode),
    .a      (a),
    .b      (b),
    .done   (w_md_done),
    .result (w_md_result),
    .ovf    (w_md_ovf)
  );
`else
  assign w_mc = 1'b0;
`endif

  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b};
    w_dif   = {1'b0, a} - {1'b0, b};
    w_sh    = b[SHW-1:0];
    w_add_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_br    = 1'b0;
    w_live  = 1'b1;
    case (opcode)
      OP_ADD, OP_ADDI: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      OP_SUB, OP_BEQ, OP_BNE, OP_BLT: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = w_sub_v;
        if (opcode == OP_BEQ) w_br = (w_dif[WIDTH-1:0] == '0);
        if (opcode == OP_BNE) w_br = (w_dif[WIDTH-1:0] != '0);
        if (opcode == OP_BLT) w_br = ($signed(a) < $signed(b));
      end
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHIFT: w_res = dir ? (a >> w_sh) : (a << w_sh);
      OP_SRA:   w_res = WIDTH'($signed(a) >>> w_sh);
      default:  w_live = 1'b0;
    endcase
  end

  // DONE with out_ready frees the slot in the same cycle, so a new request may land there.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
`ifdef ALU_MULDIV_EN
      S_BUSY: if (w_md_done) w_state_nxt = S_DONE;
`endif
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    w_accept = in_valid && in_ready;
    if (w_accept) w_state_nxt = w_mc ? S_BUSY : S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_branch   <= 1'b0;
    end else if (w_accept && !w_mc) begin
      r_result   <= w_res;
      r_zero     <= w_live && (w_res == '0);
      r_negative <= w_live && w_res[WIDTH-1];
      r_carry    <= w_c;
      r_overflow <= w_v;
      r_branch   <= w_br;
    end
`ifdef ALU_MULDIV_EN
    else if ((r_state == S_BUSY) && w_md_done) begin
      r_result   <= w_md_result;
      r_zero     <= (w_md_result == '0);
      r_negative <= w_md_result[WIDTH-1];
      r_carry    <= 1'b0;
      r_overflow <= w_md_ovf;
      r_branch   <= 1'b0;
    end
`endif
  end

  assign result       = r_result;
  assign zero         = r_zero;
  assign negative     = r_negative;
  assign carry        = r_carry;
  assign overflow     = r_overflow;
  assign branch_taken = r_branch;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int unsigned W = 8;
  localparam int MOD  = 1 << W;
  localparam int MAXS = (1 << (W - 1)) - 1;
  localparam int MINS = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic         dir;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;
  logic         branch_taken;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .dir          (dir),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .negative     (negative),
    .carry        (carry),
    .overflow     (overflow),
    .branch_taken (branch_taken)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         br;
    int           lat;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit out_of_range(input int v);
    return (v > MAXS) || (v < MINS);
  endfunction

  function automatic exp_t ref_alu(input logic [3:0] op, input logic d,
                                   input logic [W-1:0] ua, input logic [W-1:0] ub);
    exp_t e;
    int ia, ib, sa, sb, r, sh;
    bit live;
    ia = int'(ua);
    ib = int'(ub);
    sa = ua[W-1] ? ia - MOD : ia;
    sb = ub[W-1] ? ib - MOD : ib;
    sh = ib % W;
    r = 0;
    live = 1'b1;
    e.c = 1'b0;
    e.v = 1'b0;
    e.br = 1'b0;
    e.lat = 1;
    case (op)
      OP_ADD, OP_ADDI: begin
        r = ia + ib;
        e.c = (r >= MOD);
        e.v = out_of_range(sa + sb);
      end
      OP_SUB, OP_BEQ, OP_BNE, OP_BLT: begin
        r = ia - ib;
        e.c = (ia < ib);
        e.v = out_of_range(sa - sb);
        if (op == OP_BEQ) e.br = (ia == ib);
        if (op == OP_BNE) e.br = (ia != ib);
        if (op == OP_BLT) e.br = (sa < sb);
      end
      OP_AND:   r = ia & ib;
      OP_OR:    r = ia | ib;
      OP_XOR:   r = ia ^ ib;
      OP_SLT:   r = (sa < sb) ? 1 : 0;
      OP_SHIFT: r = d ? (ia >> sh) : (ia << sh);
      OP_SRA:   r = sa >>> sh;
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        r = sa * sb;
        e.lat = W + 1;
      end
      OP_DIV: begin
        e.lat = W + 1;
        if (sb == 0) r = -1;
        else if (sa == MINS && sb == -1) begin
          r = MINS;
          e.v = 1'b1;
        end else r = sa / sb;
      end
      OP_REM: begin
        e.lat = W + 1;
        if (sb == 0) r = sa;
        else r = sa % sb;
      end
`endif
      default: live = 1'b0;
    endcase
    e.res = r[W-1:0];
    e.z = live && (e.res == '0);
    e.n = live && e.res[W-1];
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic scramble();
    in_valid = 1'b1;
    opcode = 4'($urandom);
    dir = 1'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic chk_outs(input string pfx, input exp_t e);
    chk({pfx, "_res"}, result, e.res);
    chk({pfx, "_zero"}, zero, e.z);
    chk({pfx, "_neg"}, negative, e.n);
    chk({pfx, "_carry"}, carry, e.c);
    chk({pfx, "_ovf"}, overflow, e.v);
    chk({pfx, "_br"}, branch_taken, e.br);
  endtask

  // One transaction: accept, wait with out_ready low while hammering ignored requests,
  // hold the result for `hold` extra cycles, then consume it.
  task automatic run_op(input logic [3:0] op, input logic d, input logic [W-1:0] ua,
                        input logic [W-1:0] ub, input int hold);
    exp_t e;
    int lat;
    string pfx;
    pfx = $sformatf("op%0h_%0h_%0h", op, ua, ub);
    e = ref_alu(op, d, ua, ub);
    @(negedge clk);
    chk({pfx, "_idle_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1;
    opcode = op;
    dir = d;
    a = ua;
    b = ub;
    out_ready = 1'b0;
    @(posedge clk); #1;
    scramble();
    lat = 1;
    while (!out_valid && lat <= 4 * W) begin
      chk({pfx, "_busy_rdy"}, in_ready, 1'b0);
      @(posedge clk); #1;
      scramble();
      lat++;
    end
    chk({pfx, "_lat"}, lat, e.lat);
    chk_outs(pfx, e);
    chk({pfx, "_bp_rdy"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scramble();
      chk({pfx, "_hold_valid"}, out_valid, 1'b1);
      chk({pfx, "_hold_rdy"}, in_ready, 1'b0);
      chk_outs({pfx, "_hold"}, e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({pfx, "_consumed"}, out_valid, 1'b0);
  endtask

  task automatic run_b2b(input int n);
    logic [3:0] sc_ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SHIFT,
                                OP_SRA, OP_ADDI, OP_BEQ, OP_BNE, OP_BLT, OP_NOP};
    exp_t e_prev;
    bit have;
    have = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (have) begin
        chk("b2b_valid", out_valid, 1'b1);
        chk_outs("b2b", e_prev);
      end
      chk("b2b_rdy", in_ready, 1'b1);
      in_valid = 1'b1;
      opcode = sc_ops[$urandom_range(0, 12)];
      dir = 1'($urandom);
      a = pick();
      b = pick();
      e_prev = ref_alu(opcode, dir, a, b);
      have = 1'b1;
    end
    @(negedge clk);
    chk("b2b_last_valid", out_valid, 1'b1);
    chk_outs("b2b_last", e_prev);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    opcode = OP_NOP;
    dir = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_res", result, '0);
    chk("rst_flags", {zero, negative, carry, overflow, branch_taken}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_rdy", in_ready, 1'b1);

    run_op(OP_ADD, 1'b0, 8'd127, 8'd1, 3);
    chk("plan_add_res", result, 8'h80);
    chk("plan_add_flags", {zero, negative, carry, overflow}, 4'b0101);
    run_op(OP_BEQ, 1'b0, 8'd5, 8'd5, 0);
    chk("plan_beq", {zero, branch_taken, carry}, 3'b110);
    run_op(OP_BLT, 1'b0, 8'd5, 8'd5, 0);
    chk("plan_blt", branch_taken, 1'b0);
    run_op(OP_SHIFT, 1'b1, 8'h81, 8'h09, 0);
    chk("plan_srl", result, 8'h40);
    run_op(OP_SRA, 1'b0, 8'h81, 8'h09, 0);
    chk("plan_sra", result, 8'hC0);
    run_op(OP_NOP, 1'b0, 8'h12, 8'h34, 1);
    run_op(OP_MUL, 1'b0, 8'hFD, 8'd7, 1);
    run_op(OP_DIV, 1'b0, 8'hF9, 8'd2, 0);
    run_op(OP_REM, 1'b0, 8'hF9, 8'd2, 0);
    run_op(OP_DIV, 1'b0, 8'd9, 8'd0, 0);
    run_op(OP_REM, 1'b0, 8'd9, 8'd0, 0);
    run_op(OP_DIV, 1'b0, 8'h80, 8'hFF, 2);
    run_op(OP_REM, 1'b0, 8'h80, 8'hFF, 0);
`ifdef ALU_MULDIV_EN
    run_op(OP_MUL, 1'b0, 8'hFD, 8'd7, 0);
    chk("plan_mul", result, 8'hEB);
    run_op(OP_DIV, 1'b0, 8'h80, 8'hFF, 0);
    chk("plan_div_min", {result, overflow}, {8'h80, 1'b1});
`endif

    // Reset while an iterative op is in flight
    @(negedge clk);
    in_valid = 1'b1;
    opcode = OP_DIV;
    a = 8'h9C;
    b = 8'd7;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_res", result, '0);
    chk("midrst_rdy", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    run_op(OP_DIV, 1'b0, 8'd100, 8'd7, 0);

    run_b2b(12);

    for (int i = 0; i < 150; i++)
      run_op(4'($urandom), 1'($urandom), pick(), pick(), $urandom_range(0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
